traffic_checker: RTL



---
 rtl/traffic_checker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_checker.sv
// AXI4-Stream sink that checks a counting-pattern stream for sequence continuity and tlast placement.
// Latency 1 from accepted beat to statistics; tready is registered and optionally pulsed low once per STALL_PERIOD.
module traffic_checker #(
    parameter int unsigned TRANSFER_LENGTH = 256,
    parameter logic [31:0] COUNT_HIGH      = 32'hFFFF_FFFF,
    parameter int unsigned MAX_GAP         = 16,
    parameter int unsigned STALL_PERIOD    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        backpressure_en,
    input  logic [31:0] axis_tdata,
    input  logic        axis_tlast,
    input  logic        axis_tvalid,
    output logic        axis_tready,
    output logic        locked,
    output logic [31:0] beat_count,
    output logic [31:0] gap_count,
    output logic [31:0] error_count,
    output logic [31:0] tlast_error_count,
    output logic [31:0] max_gap,
    output logic [31:0] first_error_data,
    output logic        error
);

    localparam int unsigned    SCW        = $clog2(STALL_PERIOD);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_PERIOD - 1);
    localparam logic [31:0]    TL_MASK    = 32'(TRANSFER_LENGTH - 1);
    localparam logic [31:0]    GAP_LIMIT  = 32'(MAX_GAP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           tready_q, tready_d;
    logic           locked_q, locked_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]    expected_q, expected_d;
    logic [31:0]    beat_cnt_q, beat_cnt_d;
    logic [31:0]    gap_cnt_q, gap_cnt_d;
    logic [31:0]    err_cnt_q, err_cnt_d;
    logic [31:0]    tlast_err_cnt_q, tlast_err_cnt_d;
    logic [31:0]    max_gap_q, max_gap_d;
    logic [31:0]    first_err_q, first_err_d;
    logic           error_q, error_d;

    logic        beat;
    logic [31:0] delta;
    logic        last_exp;
    logic        seq_chk;
    logic        is_gap;
    logic        is_err;
    logic        tlast_bad;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] next_val(input logic [31:0] x);
        return (x >= COUNT_HIGH) ? 32'd0 : x + 32'd1;
    endfunction

    assign beat = axis_tvalid & tready_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_ACQUIRE: if (beat) state_d = ST_TRACK;
                ST_TRACK:   state_d = ST_TRACK;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!enable) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        tready_d = (state_d != ST_IDLE) && !(backpressure_en && (stall_cnt_d == STALL_LAST));
        locked_d = (state_d == ST_TRACK);
    end

    always_comb begin
        delta     = axis_tdata - expected_q;
        last_exp  = ((axis_tdata & TL_MASK) == TL_MASK);
        tlast_bad = beat && (axis_tlast != last_exp);
        seq_chk   = beat && (state_q == ST_TRACK);
        is_gap    = seq_chk && (delta != 32'd0) && (delta <= GAP_LIMIT);
        is_err    = seq_chk && (delta > GAP_LIMIT);

        expected_d = beat ? next_val(axis_tdata) : expected_q;

        beat_cnt_d      = beat_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        err_cnt_d       = err_cnt_q;
        tlast_err_cnt_d = tlast_err_cnt_q;
        max_gap_d       = max_gap_q;
        first_err_d     = first_err_q;
        error_d         = error_q;

        // A clear in the same cycle as a beat discards that beat's statistics.
        if (clear) begin
            beat_cnt_d      = '0;
            gap_cnt_d       = '0;
            err_cnt_d       = '0;
            tlast_err_cnt_d = '0;
            max_gap_d       = '0;
            first_err_d     = '0;
            error_d         = 1'b0;
        end else if (beat) begin
            beat_cnt_d = sat_inc(beat_cnt_q);
            if (is_gap) begin
                gap_cnt_d = sat_inc(gap_cnt_q);
                if (delta > max_gap_q) begin
                    max_gap_d = delta;
                end
            end
            if (is_err) begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (err_cnt_q == 32'd0) begin
                    first_err_d = axis_tdata;
                end
            end
            if (tlast_bad) begin
                tlast_err_cnt_d = sat_inc(tlast_err_cnt_q);
            end
            error_d = error_q | is_err | tlast_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tready_q        <= 1'b0;
            locked_q        <= 1'b0;
            stall_cnt_q     <= '0;
            expected_q      <= '0;
            beat_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            err_cnt_q       <= '0;
            tlast_err_cnt_q <= '0;
            max_gap_q       <= '0;
            first_err_q     <= '0;
            error_q         <= 1'b0;
        end else begin
            tready_q        <= tready_d;
            locked_q        <= locked_d;
            stall_cnt_q     <= stall_cnt_d;
            expected_q      <= expected_d;
            beat_cnt_q      <= beat_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            err_cnt_q       <= err_cnt_d;
            tlast_err_cnt_q <= tlast_err_cnt_d;
            max_gap_q       <= max_gap_d;
            first_err_q     <= first_err_d;
            error_q         <= error_d;
        end
    end

    assign axis_tready       = tready_q;
    assign locked            = locked_q;
    assign beat_count        = beat_cnt_q;
    assign gap_count         = gap_cnt_q;
    assign error_count       = err_cnt_q;
    assign tlast_error_count = tlast_err_cnt_q;
    assign max_gap           = max_gap_q;
    assign first_error_data  = first_err_q;
    assign error             = error_q;

endmodule
